// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// Moore datapath controls, with a data-memory ready timeout and a retire counter.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                beq,
  output logic                bne,
  output logic                jump,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic                busy,
  output logic [RETIRE_W-1:0] retire_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_D_LO   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_D_HI   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_BNE    = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_JUMP   = OPCODE_W'(14);

  localparam logic [ALU_OP_W-1:0] ALU_DTYPE  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_BRANCH = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_ADDR   = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_JUMP   = ALU_OP_W'(3);

  localparam int              TO_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [TO_W-1:0]     to_cnt;
  logic [TO_W-1:0]     to_inc;
  logic                retire;
  logic                end_instr;
  logic                timeout_hit;
  logic                is_lw, is_sw, is_dtype, is_beq, is_bne, is_jump;

  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return op <= OP_JUMP;
  endfunction

  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_dtype = (op_q >= OP_D_LO) && (op_q <= OP_D_HI);
  assign is_beq   = (op_q == OP_BEQ);
  assign is_bne   = (op_q == OP_BNE);
  assign is_jump  = (op_q == OP_JUMP);
  assign to_inc   = to_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    end_instr   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:   if (en) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_dtype)              state_nxt = S_WB;
        else if (is_lw || is_sw)   state_nxt = S_MEM;
        else begin
          // Illegal opcodes pass through EXEC with no controls and do not retire.
          end_instr = 1'b1;
          retire    = is_beq || is_bne || is_jump;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_lw) state_nxt = S_WB;
          else begin
            end_instr = 1'b1;
            retire    = 1'b1;
          end
        end else if ((MEM_TIMEOUT != 0) && (to_inc == TO_LIMIT)) begin
          end_instr   = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      S_WB: begin
        end_instr = 1'b1;
        retire    = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (end_instr) state_nxt = en ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      to_cnt      <= '0;
      retire_cnt  <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      if (state == S_DECODE) op_q <= opcode;
      if (state == S_EXEC)                 to_cnt <= '0;
      else if (state == S_MEM && !mem_ready) to_cnt <= to_inc;
      retire_cnt  <= retire_cnt + RETIRE_W'(retire);
      illegal_op  <= (state == S_DECODE) && !op_legal(opcode);
      mem_timeout <= timeout_hit;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_DTYPE;
    case (state)
      S_FETCH: begin
        pc_write = 1'b1;
        ir_write = 1'b1;
      end
      S_EXEC: begin
        if (is_dtype) reg_dst = 1'b1;
        else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          alu_op  = ALU_ADDR;
        end else if (is_beq) begin
          beq     = 1'b1;
          reg_dst = 1'b1;
          alu_op  = ALU_BRANCH;
        end else if (is_bne) begin
          bne    = 1'b1;
          alu_op = ALU_BRANCH;
        end else if (is_jump) begin
          jump   = 1'b1;
          alu_op = ALU_JUMP;
        end
      end
      S_MEM: begin
        // Address path held stable for the whole access.
        alu_src   = 1'b1;
        alu_op    = ALU_ADDR;
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        reg_dst    = is_dtype;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table plus
// hand sequences for MEM timeout, ready-at-limit, retire wrap and mid-access reset.
module tb_multicycle_control_unit;

  // Control word: {pc_write, ir_write, reg_dst, alu_src, mem_to_reg, reg_write,
  //                mem_read, mem_write, beq, bne, jump, alu_op[1:0], illegal_op, mem_timeout, busy}
  localparam logic [15:0] C_IDLE   = 16'h0000;
  localparam logic [15:0] C_FETCH  = 16'hC001;
  localparam logic [15:0] C_FET_TO = 16'hC003;
  localparam logic [15:0] C_DEC    = 16'h0001;
  localparam logic [15:0] C_EX_D   = 16'h2001;
  localparam logic [15:0] C_EX_M   = 16'h1011;
  localparam logic [15:0] C_MEM_R  = 16'h1211;
  localparam logic [15:0] C_MEM_W  = 16'h1111;
  localparam logic [15:0] C_WB_D   = 16'h2401;
  localparam logic [15:0] C_WB_L   = 16'h0C01;
  localparam logic [15:0] C_EX_BEQ = 16'h2089;
  localparam logic [15:0] C_EX_BNE = 16'h0049;
  localparam logic [15:0] C_EX_J   = 16'h0039;
  localparam logic [15:0] C_EX_ILL = 16'h0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_dst, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, beq, bne, jump, illegal_op, mem_timeout, busy;
  logic [1:0]  alu_op;
  logic [15:0] retire_cnt;
  logic [15:0] ctl;
  logic [15:0] ctl_w;
  logic [2:0]  retire_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .beq(beq), .bne(bne), .jump(jump), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .busy(busy),
    .retire_cnt(retire_cnt)
  );

  // Narrow retire counter instance so counter wrap is reachable in a short run.
  multicycle_control_unit #(.RETIRE_W(3)) dut_w (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(ctl_w[15]), .ir_write(ctl_w[14]), .reg_dst(ctl_w[13]), .alu_src(ctl_w[12]),
    .mem_to_reg(ctl_w[11]), .reg_write(ctl_w[10]), .mem_read(ctl_w[9]),
    .mem_write(ctl_w[8]), .beq(ctl_w[7]), .bne(ctl_w[6]), .jump(ctl_w[5]),
    .alu_op(ctl_w[4:3]), .illegal_op(ctl_w[2]), .mem_timeout(ctl_w[1]), .busy(ctl_w[0]),
    .retire_cnt(retire_w)
  );

  assign ctl = {pc_write, ir_write, reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                mem_write, beq, bne, jump, alu_op, illegal_op, mem_timeout, busy};

  typedef struct {
    logic        en;
    logic [3:0]  op;
    logic        rdy;
    logic [15:0] ctl;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic e, input logic [3:0] o, input logic r,
                              input logic [15:0] c, input logic [15:0] n);
    vec_t v;
    v.en = e; v.op = o; v.rdy = r; v.ctl = c; v.ret = n;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs for the coming rising edge; outputs are sampled 1 time unit later.
  task automatic step(input logic e, input logic [3:0] o, input logic r);
    @(negedge clk);
    en = e; opcode = o; mem_ready = r;
    #1;
  endtask

  task automatic chk_cyc(input string name, input logic [15:0] c, input logic [15:0] n);
    chk({name, "_ctl"}, 32'(ctl), 32'(c));
    chk({name, "_ret"}, 32'(retire_cnt), 32'(n));
    chk({name, "_retw"}, 32'(retire_w), 32'(n[2:0]));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; opcode = 4'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_ret", 32'(retire_cnt), 32'd0);
    rst = 1'b0;

    // ADD, LW with 2 wait cycles, SW, JUMP, illegal, BEQ/BNE parking in IDLE, D-type op 11
    add(0, 0, 0, C_IDLE, 0);   add(1, 0, 0, C_IDLE, 0);
    add(1, 0, 0, C_FETCH, 0);  add(1, 2, 0, C_DEC, 0);
    add(1, 0, 0, C_EX_D, 0);   add(1, 0, 0, C_WB_D, 0);
    add(1, 0, 0, C_FETCH, 1);  add(1, 0, 0, C_DEC, 1);
    add(1, 0, 0, C_EX_M, 1);   add(1, 0, 0, C_MEM_R, 1);
    add(1, 0, 0, C_MEM_R, 1);  add(1, 0, 1, C_MEM_R, 1);
    add(1, 0, 0, C_WB_L, 1);   add(1, 0, 0, C_FETCH, 2);
    add(1, 1, 0, C_DEC, 2);    add(1, 0, 0, C_EX_M, 2);
    add(1, 0, 1, C_MEM_W, 2);  add(1, 0, 0, C_FETCH, 3);
    add(1, 14, 0, C_DEC, 3);   add(1, 0, 0, C_EX_J, 3);
    add(1, 0, 0, C_FETCH, 4);  add(1, 15, 0, C_DEC, 4);
    add(1, 0, 0, C_EX_ILL, 4); add(1, 0, 0, C_FETCH, 4);
    add(1, 12, 0, C_DEC, 4);   add(0, 0, 0, C_EX_BEQ, 4);
    add(0, 0, 0, C_IDLE, 5);   add(1, 0, 0, C_IDLE, 5);
    add(0, 0, 0, C_FETCH, 5);  add(0, 13, 0, C_DEC, 5);
    add(0, 0, 0, C_EX_BNE, 5); add(0, 0, 0, C_IDLE, 6);
    add(1, 0, 0, C_IDLE, 6);   add(1, 0, 0, C_FETCH, 6);
    add(1, 11, 0, C_DEC, 6);   add(1, 0, 0, C_EX_D, 6);
    add(1, 0, 0, C_WB_D, 6);   add(1, 0, 0, C_FETCH, 7);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].op, tbl[i].rdy);
      chk_cyc($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].ret);
    end

    // SW with mem_ready never high: 15 MEM cycles, then timeout pulse in next FETCH
    step(1, 1, 0); chk_cyc("sw_to_dec", C_DEC, 7);
    step(1, 0, 0); chk_cyc("sw_to_exec", C_EX_M, 7);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0); chk_cyc($sformatf("sw_to_mem%0d", i), C_MEM_W, 7);
    end
    step(1, 0, 0); chk_cyc("sw_to_pulse", C_FET_TO, 7);

    // SW whose ready arrives on the 15th MEM cycle: ready beats timeout
    step(1, 1, 0); chk_cyc("sw_lim_dec", C_DEC, 7);
    step(1, 0, 0); chk_cyc("sw_lim_exec", C_EX_M, 7);
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0); chk_cyc($sformatf("sw_lim_mem%0d", i), C_MEM_W, 7);
    end
    step(1, 0, 1); chk_cyc("sw_lim_last", C_MEM_W, 7);
    step(1, 0, 0); chk_cyc("sw_lim_retire", C_FETCH, 8);
    chk("retw_wrap", 32'(retire_w), 32'd0);

    for (int k = 0; k < 2; k++) begin
      step(1, 14, 0); chk_cyc($sformatf("jmp%0d_dec", k), C_DEC, 16'(8 + k));
      step(1, 0, 0);  chk_cyc($sformatf("jmp%0d_exec", k), C_EX_J, 16'(8 + k));
      step(1, 0, 0);  chk_cyc($sformatf("jmp%0d_fetch", k), C_FETCH, 16'(9 + k));
    end

    // Reset in the middle of an LW memory wait
    step(1, 0, 0); chk_cyc("lw_rst_dec", C_DEC, 10);
    step(1, 0, 0); chk_cyc("lw_rst_exec", C_EX_M, 10);
    step(1, 0, 0); chk_cyc("lw_rst_mem0", C_MEM_R, 10);
    step(1, 0, 0); chk_cyc("lw_rst_mem1", C_MEM_R, 10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("async_rst_ret", 32'(retire_cnt), 32'd0);
    en = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1); chk_cyc($sformatf("post_rst_idle%0d", i), C_IDLE, 0);
    end
    step(1, 0, 0); chk_cyc("post_rst_en", C_IDLE, 0);
    step(1, 0, 0); chk_cyc("post_rst_fetch", C_FETCH, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
